// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_pkg
//  Purpose  : Shared definitions for the dual-port memory subsystem: memory
//             word/address widths (shared with mem_cpu), the port-B DMA
//             state encoding and the DMA command direction codes.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  // Command direction codes carried on cmd_write.
  localparam logic CMD_LOAD = 1'b1;  // host -> memory
  localparam logic CMD_DUMP = 1'b0;  // memory -> host

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RD_ADDR = 3'd2,
    RD_WAIT = 3'd3,
    RD_HOLD = 3'd4,
    FINISH  = 3'd5
  } dma_state_t;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_port_b_dma.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_b_dma
//  Purpose  : Host-side DMA engine owning port B of the shared dual-port
//             memory. Loads a burst of words into memory (host->mem) or
//             dumps a burst out of memory (mem->host) under a command plus
//             valid/ready data streams.
//  Ports    :
//    clk        in   system clock, rising edge
//    reset      in   asynchronous active-low reset
//    cmd_*      in   command: valid, write(1=load/0=dump), addr, len
//    cmd_ready  out  high only while idle
//    wr_*            load data stream (valid/ready/data)
//    rd_*            dump data stream (valid/ready/data)
//    busy       out  high whenever a burst is in progress
//    done       out  one-cycle pulse at burst end
//    address_b, data_b, wren_b  out  registered memory port B controls
//    q_b        in   memory port B read data, valid 1 clk after address_b
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_b_dma #(
  parameter int DATA_W = mem_pkg::DATA_W,
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] address_b,
  output logic [DATA_W-1:0] data_b,
  output logic              wren_b,
  input  logic [DATA_W-1:0] q_b
);

  import mem_pkg::*;

  dma_state_t        state;
  logic [ADDR_W-1:0] ptr;        // next memory address of the burst
  logic [LEN_W-1:0]  remaining;  // words still to transfer

  // Every output is a register; the async reset therefore clears wren_b,
  // busy and rd_valid the instant reset falls, aborting any burst.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      done      <= 1'b0;
      address_b <= '0;
      data_b    <= '0;
      wren_b    <= 1'b0;
    end else begin
      // Single-cycle strobes default low.
      done   <= 1'b0;
      wren_b <= 1'b0;

      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            ptr       <= cmd_addr;
            remaining <= cmd_len;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_len == '0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else if (cmd_write == CMD_LOAD) begin
              state    <= WRITE;
              wr_ready <= 1'b1;
            end else begin
              // Address is registered on entry so it is already on the
              // port during RD_ADDR and q_b is valid during RD_WAIT.
              state     <= RD_ADDR;
              address_b <= cmd_addr;
            end
          end
        end

        WRITE: begin
          if (wr_valid && wr_ready) begin
            address_b <= ptr;
            data_b    <= wr_data;
            wren_b    <= 1'b1;
            ptr       <= ptr + 1'b1;
            remaining <= remaining - 1'b1;
            // Last word: its wren_b cycle is also the FINISH/done cycle.
            if (remaining == LEN_W'(1)) begin
              state    <= FINISH;
              done     <= 1'b1;
              wr_ready <= 1'b0;
            end
          end
        end

        RD_ADDR: begin
          state <= RD_WAIT;
        end

        RD_WAIT: begin
          rd_data  <= q_b;
          rd_valid <= 1'b1;
          state    <= RD_HOLD;
        end

        RD_HOLD: begin
          // rd_data is not touched here, so it stays stable while stalled.
          if (rd_ready) begin
            rd_valid  <= 1'b0;
            ptr       <= ptr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == LEN_W'(1)) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state     <= RD_ADDR;
              address_b <= ptr + 1'b1;
            end
          end
        end

        FINISH: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          wr_ready  <= 1'b0;
          rd_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule : mem_port_b_dma
`default_nettype wire

// File: doc/mem_port_b_dma.md
Name: mem_port_b_dma

Overview:
- Host-side DMA engine that owns port B of the shared 16-bit dual-port memory.
- The CPU remains the initiator on port A; this block is the other end of the memory interface on port B.
- Loads words into memory (host→mem) and dumps words out of memory (mem→host) under a simple command plus valid/ready streams.
- Sits beside mem_cpu at top level: drives address_b/data_b/wren_b and consumes q_b.

Parameters:
- DATA_W, 16, memory word width (matches data_b/q_b)
- ADDR_W, 16, memory address width (matches address_b)
- LEN_W, 16, burst length counter width

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  high only in IDLE
- cmd_write  input  1  1 = load (host→mem), 0 = dump (mem→host)
- cmd_addr  input  ADDR_W  burst start address
- cmd_len  input  LEN_W  number of words; 0 allowed
- wr_valid  input  1  load data valid
- wr_ready  output  1  load data accepted
- wr_data  input  DATA_W  load word
- rd_valid  output  1  dump word valid
- rd_ready  input  1  host accepts dump word
- rd_data  output  DATA_W  dump word
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse at burst end
- address_b  output  ADDR_W  memory port B address (registered)
- data_b  output  DATA_W  memory port B write data (registered)
- wren_b  output  1  memory port B write enable (registered)
- q_b  input  DATA_W  memory port B read data; valid 1 clk after address_b

Behaviour:
- Reset (reset=0, async):
  - state=IDLE
  - all outputs 0, except cmd_ready=1
  - address_b, data_b, rd_data = 0
  - Assertion mid-burst aborts immediately: wren_b drops without waiting for a clock edge, no done pulse, remaining words are discarded.
- States: IDLE, WRITE, RD_ADDR, RD_WAIT, RD_HOLD, FINISH.
- IDLE:
  - On cmd_valid&&cmd_ready, latch addr and len into internal ptr and remaining.
  - len==0 → FINISH with no memory access.
  - cmd_write=1 → WRITE; cmd_write=0 → RD_ADDR.
- WRITE:
  - wr_ready = (remaining!=0).
  - Each wr_valid&&wr_ready handshake registers address_b=ptr, data_b=wr_data, wren_b=1 for exactly the next cycle; then ptr+=1 and remaining-=1.
  - wren_b is 0 in every cycle without a handshake in the previous cycle.
  - Back-to-back handshakes give one write per cycle.
  - After the last handshake → FINISH. The final wren_b cycle coincides with the first FINISH cycle.
- RD_ADDR: drive address_b=ptr, wren_b=0 → RD_WAIT.
- RD_WAIT: capture q_b into rd_data, set rd_valid=1 → RD_HOLD.
- RD_HOLD:
  - rd_data is held stable while rd_valid && !rd_ready.
  - On handshake: rd_valid=0, ptr+=1, remaining-=1.
  - If remaining becomes 0 → FINISH, else → RD_ADDR.
  - Throughput: 1 word per 3 cycles with rd_ready held high.
- FINISH: done=1 for one cycle → IDLE.
- Address arithmetic: ptr wraps modulo 2^ADDR_W (0xFFFF+1 → 0x0000), with no error. remaining is unsigned and never underflows.
- Outside WRITE, wr_ready=0; wr_valid there is ignored and not consumed.
- New commands are only accepted in IDLE (cmd_ready=0 otherwise). A command arriving in the same cycle as done is held off until IDLE.
- No arbitration with port A: software must not target the same address from both ports in the same cycle; memory behaviour in that case is outside this block.

Decomposition:
- Shared package mem_pkg holds:
  - DATA_W and ADDR_W constants, shared with mem_cpu
  - the dma_state_t enum (IDLE..FINISH)
  - the CMD_LOAD=1 and CMD_DUMP=0 constants
- Single module; no sub-module. The pointer/length counter stays inline.

Test Plan:
- Load: cmd write, addr 0x0010, len 4; wr_data 0xA001..0xA004 with wr_valid held → wren_b high 4 consecutive cycles at 0x0010..0x0013, then done pulses once; memory model holds those values.
- Dump with backpressure: preload 0x0010..0x0013; cmd dump, same range; rd_ready toggles 1/0 → rd_data 0xA001..0xA004 in order, each word stable while stalled, done after 4th handshake.
- Wrap: load addr 0xFFFE, len 3, data 1,2,3 → writes land at 0xFFFE, 0xFFFF, 0x0000.
- Zero length: cmd len 0 (either direction) → no wren_b, no rd_valid, done 1 cycle after acceptance, cmd_ready back 1 cycle later.
- Stalled load: wr_valid gapped (1,0,0,1,1) for len 3 → wren_b only in cycles following handshakes, addresses consecutive, cmd_ready=0 throughout.
- Reset mid-burst: assert reset (low) after 2 of 4 load words → wren_b, busy, rd_valid drop asynchronously; after release, cmd_ready=1 and no done pulse.
